// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hold/bubble/flush/freeze sequencing for the 5-stage ARM pipeline
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             hazard_stall,
  output logic             idex_flush,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ex_qual;
  logic              mem_qual;
  logic              hit1;
  logic              hit2;
  logic              src_hit;
  logic              freeze_cond;

  // With forwarding only a load in EX cannot be bypassed; without it every in-flight writer blocks.
  assign ex_qual  = ex_wb_en & (fwd_en ? ex_mem_read : 1'b1);
  assign mem_qual = ~fwd_en & mem_wb_en;
  assign hit1     = id_use_src1 & ((ex_qual & (id_src1 == ex_dest)) | (mem_qual & (id_src1 == mem_dest)));
  assign hit2     = id_use_src2 & ((ex_qual & (id_src2 == ex_dest)) | (mem_qual & (id_src2 == mem_dest)));
  assign src_hit  = hit1 | hit2;

  assign freeze_cond = (state == RUN) ? (mem_req & ~mem_ready)
                                      : (~mem_ready & (wait_cnt < TIMEOUT_V));

  always_comb begin
    hazard_stall = 1'b0;
    idex_flush   = 1'b0;
    ifid_flush   = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst) begin
      if (freeze_cond) begin
        pipe_freeze = 1'b1;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (src_hit) begin
        hazard_stall = 1'b1;
        idex_flush   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEMWAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEMWAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= TIMEOUT_V) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase

      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if ((hazard_stall || pipe_freeze) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en;
  logic [3:0] id_src1, id_src2;
  logic       id_use_src1, id_use_src2;
  logic [3:0] ex_dest;
  logic       ex_wb_en, ex_mem_read;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       branch_taken, mem_req, mem_ready, cnt_clr;
  logic       hazard_stall, idex_flush, ifid_flush, pipe_freeze, mem_timeout;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int frz;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .cnt_clr(cnt_clr),
    .hazard_stall(hazard_stall), .idex_flush(idex_flush), .ifid_flush(ifid_flush),
    .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fwd_en = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
    ex_dest = 0; ex_wb_en = 0; ex_mem_read = 0; mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    // hazard and memory-wait inputs active while in reset
    ex_wb_en = 1; ex_dest = 3; id_src1 = 3; id_use_src1 = 1; mem_req = 1;
    tick(); #1;
    chk("rst_hazard_stall", hazard_stall, 0);
    chk("rst_idex_flush", idex_flush, 0);
    chk("rst_pipe_freeze", pipe_freeze, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    idle();
    #1 rst = 0;

    // load-use with forwarding
    tick();
    fwd_en = 1; ex_mem_read = 1; ex_wb_en = 1; ex_dest = 3; id_src1 = 3; id_use_src1 = 1;
    #1;
    chk("lu_hazard_stall", hazard_stall, 1);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    tick();
    ex_mem_read = 0; ex_wb_en = 0; mem_dest = 3; mem_wb_en = 1;
    #1;
    chk("lu_mem_fwd_no_stall", hazard_stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    ex_wb_en = 1; ex_dest = 3; ex_mem_read = 0; mem_wb_en = 0;
    #1;
    chk("lu_alu_fwd_no_stall", hazard_stall, 0);
    idle();
    clr_cnt();
    chk("clr_cnt", stall_cnt, 0);

    // no forwarding: producer in EX then MEM
    fwd_en = 0; id_src2 = 5; id_use_src2 = 1; ex_dest = 5; ex_wb_en = 1;
    #1;
    chk("nf_ex_stall", hazard_stall, 1);
    tick();
    ex_wb_en = 0; ex_dest = 0; mem_dest = 5; mem_wb_en = 1;
    #1;
    chk("nf_mem_stall", hazard_stall, 1);
    tick();
    mem_wb_en = 0;
    #1;
    chk("nf_released", hazard_stall, 0);
    chk("nf_cnt", stall_cnt, 2);
    ex_dest = 5; ex_wb_en = 1; id_use_src2 = 0;
    #1;
    chk("nf_unused_src2", hazard_stall, 0);
    id_use_src1 = 1; id_src1 = 4;
    #1;
    chk("nf_src1_mismatch", hazard_stall, 0);

    // branch beats hazard
    idle();
    fwd_en = 0; ex_dest = 7; ex_wb_en = 1; id_src1 = 7; id_use_src1 = 1; branch_taken = 1;
    #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    chk("br_hazard_stall", hazard_stall, 0);
    tick();
    chk("br_cnt_unchanged", stall_cnt, 2);
    idle();
    clr_cnt();

    // memory wait of 4 cycles with a simultaneous taken branch
    frz = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_ready = 0; branch_taken = 1;
      #1;
      frz += pipe_freeze;
      chk("mw_branch_suppressed", ifid_flush, 0);
      tick();
    end
    chk("mw_freeze_cycles", frz, 4);
    mem_ready = 1;
    #1;
    chk("mw_ready_no_freeze", pipe_freeze, 0);
    chk("mw_branch_after", ifid_flush, 1);
    tick();
    idle();
    #1;
    chk("mw_back_in_run", pipe_freeze, 0);
    chk("mw_cnt", stall_cnt, 4);

    // single-cycle access
    mem_req = 1; mem_ready = 1;
    #1;
    chk("sc_no_freeze", pipe_freeze, 0);
    tick();
    mem_req = 0; mem_ready = 0;
    #1;
    chk("sc_stayed_run", pipe_freeze, 0);
    clr_cnt();

    // timeout with MEM_TIMEOUT = 8
    frz = 0;
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      frz += pipe_freeze;
      if (i == 8) begin
        chk("to_release_cycle", pipe_freeze, 0);
        chk("to_flag_not_yet", mem_timeout, 0);
      end
      tick();
    end
    chk("to_freeze_cycles", frz, 8);
    chk("to_flag", mem_timeout, 1);
    chk("to_new_wait", pipe_freeze, 1);
    chk("to_cnt", stall_cnt, 8);
    tick();
    mem_ready = 1;
    #1;
    chk("to_new_wait_ready", pipe_freeze, 0);
    tick();
    idle();
    #1;
    chk("to_cnt2", stall_cnt, 9);
    chk("to_flag_sticky", mem_timeout, 1);

    // saturation at 15 and clear priority
    fwd_en = 0; ex_dest = 2; ex_wb_en = 1; id_src1 = 2; id_use_src1 = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt", stall_cnt, 15);
    cnt_clr = 1;
    #1;
    chk("clr_with_stall_hs", hazard_stall, 1);
    tick();
    chk("clr_with_stall", stall_cnt, 0);
    idle();

    // reset during the 3rd MEMWAIT cycle
    mem_req = 1; mem_ready = 0;
    tick(); tick(); tick();
    #1;
    chk("rm_frozen", pipe_freeze, 1);
    rst = 1;
    #1;
    chk("rm_freeze_cleared", pipe_freeze, 0);
    chk("rm_flag_cleared", mem_timeout, 0);
    chk("rm_cnt_cleared", stall_cnt, 0);
    mem_req = 0;
    #1;
    rst = 0;
    #1;
    chk("rm_state_run", pipe_freeze, 0);
    tick();
    #1;
    chk("rm_still_run", pipe_freeze, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage ARM core. It generates the hold, bubble and flush controls for the PC, the IF/ID register and the ID/EX register (`flush` input). It detects register-read hazards between the ID stage and the EX/MEM stages and squashes wrong-path instructions on a taken branch. It also freezes the whole pipeline while the data memory is not ready, with a timeout and a stall-cycle counter.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive memory-wait cycles before forced release.
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fwd_en`  in  1  forwarding unit enabled.
- `id_src1`, `id_src2`  in  4  register numbers read by the instruction in ID.
- `id_use_src1`, `id_use_src2`  in  1  the corresponding source is actually read.
- `ex_dest`  in  4  destination register of the instruction in EX.
- `ex_wb_en`  in  1  EX instruction writes back.
- `ex_mem_read`  in  1  EX instruction is a load.
- `mem_dest`  in  4  destination register of the instruction in MEM.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `branch_taken`  in  1  branch resolved taken in EX this cycle.
- `mem_req`  in  1  MEM stage is issuing a read or write.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `hazard_stall`  out  1  hold PC and IF/ID.
- `idex_flush`  out  1  load a bubble into ID/EX.
- `ifid_flush`  out  1  clear IF/ID.
- `pipe_freeze`  out  1  hold every pipeline register, PC included.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled cycles.

## Operation
- **States:** RUN and MEMWAIT. A `wait_cnt` register, 8 bits minimum and sized for `MEM_TIMEOUT`, counts cycles spent in MEMWAIT.
- **`src_hit`:** true when either condition holds:
  - `id_use_src1` and `id_src1` matches a qualifying destination.
  - `id_use_src2` and `id_src2` matches a qualifying destination.
- **Qualifying destination:**
  - When `fwd_en`=1: only `ex_dest`, and only if `ex_wb_en` and `ex_mem_read` are both 1 (load-use).
  - When `fwd_en`=0: `ex_dest` if `ex_wb_en`, or `mem_dest` if `mem_wb_en`.
- **`freeze_cond`:**
  - In RUN: `mem_req` & !`mem_ready`.
  - In MEMWAIT: !`mem_ready` & (`wait_cnt` < `MEM_TIMEOUT`).
- **Output priority**, evaluated combinationally each cycle:
  1. If `freeze_cond`: `pipe_freeze`=1, and all other control outputs are 0. A branch or hazard is re-evaluated once the pipeline moves again.
  2. Else if `branch_taken`: `ifid_flush`=1, `idex_flush`=1, `hazard_stall`=0.
  3. Else if `src_hit`: `hazard_stall`=1, `idex_flush`=1.
  4. Else all control outputs are 0.
- **Transition RUN → MEMWAIT:** taken when `mem_req` & !`mem_ready`. `wait_cnt` is loaded with 1.
- **MEMWAIT behaviour:**
  - `mem_ready`=1: return to RUN; the pipeline advances that cycle (no freeze).
  - `wait_cnt` = `MEM_TIMEOUT` and !`mem_ready`: set `mem_timeout`=1, return to RUN, no freeze that cycle.
  - Otherwise: increment `wait_cnt` and stay in MEMWAIT.
- **`mem_timeout`:** stays set until `rst`.
- **`stall_cnt`:**
  - Increments each cycle `hazard_stall` | `pipe_freeze` is 1.
  - Saturates at all ones.
  - `cnt_clr` has priority over increment and clears it to 0.
- **Without forwarding:** a dependence on EX produces two consecutive stall cycles (EX, then MEM). A dependence on MEM produces one stall cycle.

## Timing
- Reset values: state RUN, `wait_cnt` 0, `mem_timeout` 0, `stall_cnt` 0.
- While `rst` is high: `hazard_stall`, `idex_flush`, `ifid_flush` and `pipe_freeze` are driven 0.
- Reset asserted mid-MEMWAIT forces RUN immediately, asynchronously.
- All control outputs are combinational from the inputs and the current state; there is zero-cycle latency from input to control.
- State, `wait_cnt`, `mem_timeout` and `stall_cnt` update on the `clk` rising edge.
- A single-cycle access (`mem_req` & `mem_ready` in the same cycle) never enters MEMWAIT and produces no freeze.
- Maximum freeze length is `MEM_TIMEOUT` cycles: one cycle in RUN plus `MEM_TIMEOUT`−1 cycles in MEMWAIT.
- `mem_req` is ignored while in MEMWAIT. The MEM stage is frozen, so the request is held by construction.

## Test plan
- **Load-use with forwarding:** `fwd_en`=1, `ex_mem_read`=1, `ex_wb_en`=1, `ex_dest`=3, `id_src1`=3, `id_use_src1`=1 → `hazard_stall`=1 and `idex_flush`=1 for exactly one cycle. With `ex_mem_read`=0 → no stall.
- **No forwarding:** `fwd_en`=0, ID reads R5 as src2, producer in EX then MEM over two cycles → 2 stall cycles, `stall_cnt`=2. With `id_use_src2`=0 → 0 stalls.
- **Branch vs hazard:** `branch_taken`=1 together with a `src_hit` → `ifid_flush`=1, `idex_flush`=1, `hazard_stall`=0.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 4 cycles, then high → `pipe_freeze` high for 4 cycles and low on the ready cycle. A simultaneous `branch_taken` is suppressed while frozen. Final `stall_cnt`=4.
- **Timeout:** `MEM_TIMEOUT`=8, `mem_ready` held low → `pipe_freeze` for 8 cycles, then `mem_timeout`=1, state RUN. If `mem_req` stays high and `mem_ready` low, a new wait begins the following cycle.
- **Reset and counter:**
  - Assert `rst` during the 3rd MEMWAIT cycle → outputs 0 immediately, state RUN.
  - Drive `stall_cnt` to all ones with `CNT_W`=4 → holds at 15.
  - `cnt_clr` together with a stall → 0.
